keypad4x4_scanner: RTL and testbench

Matrix-keypad input block; the input-side counterpart of the multiplexed 7-segment display driver. It strobes the four rows of a 4x4 membrane keypad one at a time and samples the four column lines. Each full scan is reduced to a key snapshot, which is then debounced. The block reports the pressed key as a hex nibble, so its `hexx` output can feed the display driver's `hexx` input directly.

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/sync2.sv | 29 ++
 rtl/keypad4x4_scanner.sv | 236 +++++++++++++++++++++++
 tb/tb_keypad4x4_scanner.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and constants for the 4x4 keypad scanner
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int NKEYS = ROWS * ROWS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_PRESSED,
        ST_RELEASE_DB
    } db_state_t;

    typedef enum logic [1:0] {
        SNAP_NONE,
        SNAP_KEY,
        SNAP_GHOST
    } snap_kind_t;

    // idx = {row[1:0], col[1:0]}; '*' reports as E and '#' as F
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - 4-bit two-flop synchronizer for the keypad column lines, idles high
module sync2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_meta;
    logic [3:0] r_q;

    // two-stage capture; clear forces the released (all-high) column state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 4'b1111;
            r_q    <= 4'b1111;
        end else if (i_clr) begin
            r_meta <= 4'b1111;
            r_q    <= 4'b1111;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/keypad4x4_scanner.sv
// rtl/keypad4x4_scanner.sv - 4x4 keypad row scanner with snapshot debounce; KEYPAD_HISTORY_EN enables 4-key hexx history
module keypad4x4_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W     = 10,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] hexx
);

    localparam logic [SCAN_DIV_W-1:0] DIV_MAX = '1;
    localparam logic [3:0]            DB_N    = 4'(DEBOUNCE_SCANS);

    logic [SCAN_DIV_W-1:0] r_div;
    logic [1:0]            r_row;
    logic [3:0]            r_rows;
    logic [NKEYS-1:0]      r_snap;
    logic                  r_eval;

    logic [3:0]            w_cols_s;
    logic                  w_slot_end;
    logic [1:0]            w_row_next;

    logic [4:0]            w_nkeys;
    logic [3:0]            w_idx;
    snap_kind_t            w_kind;

    db_state_t             r_state;
    db_state_t             w_state_nx;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nx;
    logic [3:0]            r_cand;
    logic [3:0]            w_cand_nx;
    logic [3:0]            r_code;
    logic [3:0]            w_code_nx;
    logic                  r_valid;
    logic                  w_valid_nx;
    logic                  r_held;
    logic                  w_held_nx;
    logic                  w_accept;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (!en),
        .i_d   (cols),
        .o_q   (w_cols_s)
    );

    assign w_slot_end = (r_div == DIV_MAX);
    assign w_row_next = r_row + 2'd1;

    // row strobe, divider and per-row column capture; a scan completes on the row 3 sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_row  <= 2'd0;
            r_rows <= 4'b1111;
            r_snap <= '0;
            r_eval <= 1'b0;
        end else if (!en) begin
            r_div  <= '0;
            r_row  <= 2'd0;
            r_rows <= 4'b1111;
            r_snap <= '0;
            r_eval <= 1'b0;
        end else begin
            r_div  <= r_div + 1'b1;
            r_eval <= 1'b0;
            if (w_slot_end) begin
                r_snap[{r_row, 2'b00} +: 4] <= ~w_cols_s;
                r_row  <= w_row_next;
                r_rows <= ~(4'b0001 << w_row_next);
                if (r_row == 2'd3) begin
                    r_eval <= 1'b1;
                end
            end else begin
                r_rows <= ~(4'b0001 << r_row);
            end
        end
    end

    // reduce the full-scan snapshot to NONE / KEY(idx) / GHOST
    always_comb begin
        w_nkeys = '0;
        w_idx   = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (r_snap[i]) begin
                w_nkeys = w_nkeys + 5'd1;
                w_idx   = 4'(i);
            end
        end
        if (w_nkeys == 5'd0) begin
            w_kind = SNAP_NONE;
        end else if (w_nkeys == 5'd1) begin
            w_kind = SNAP_KEY;
        end else begin
            w_kind = SNAP_GHOST;
        end
    end

    // debounce next-state: count agreeing snapshots before accepting a press or a release
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        w_held_nx  = r_held;
        w_accept   = 1'b0;
        if (r_eval) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_kind == SNAP_KEY) begin
                        w_cand_nx = w_idx;
                        if (DB_N == 4'd1) begin
                            w_accept = 1'b1;
                        end else begin
                            w_cnt_nx   = 4'd1;
                            w_state_nx = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (w_kind == SNAP_KEY) begin
                        if (w_idx == r_cand) begin
                            if (r_cnt + 4'd1 == DB_N) begin
                                w_accept = 1'b1;
                            end else begin
                                w_cnt_nx = r_cnt + 4'd1;
                            end
                        end else begin
                            w_cand_nx = w_idx;
                            w_cnt_nx  = 4'd1;
                        end
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = 4'd0;
                    end
                end
                ST_PRESSED: begin
                    if (w_kind == SNAP_NONE || (w_kind == SNAP_KEY && w_idx != r_cand)) begin
                        if (DB_N == 4'd1) begin
                            w_held_nx  = 1'b0;
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = 4'd0;
                        end else begin
                            w_cnt_nx   = 4'd1;
                            w_state_nx = ST_RELEASE_DB;
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_kind == SNAP_KEY && w_idx == r_cand) begin
                        w_state_nx = ST_PRESSED;
                        w_cnt_nx   = 4'd0;
                    end else if (w_kind != SNAP_GHOST) begin
                        if (r_cnt + 4'd1 == DB_N) begin
                            w_held_nx  = 1'b0;
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = 4'd0;
                        end else begin
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 4'd0;
                end
            endcase
        end
        if (w_accept) begin
            w_code_nx  = key_map(w_cand_nx);
            w_valid_nx = 1'b1;
            w_held_nx  = 1'b1;
            w_state_nx = ST_PRESSED;
            w_cnt_nx   = 4'd0;
        end
    end

    // debounce state register; disabling drops the held key but keeps the last code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_cand  <= 4'd0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else if (!en) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
            r_held  <= w_held_nx;
        end
    end

`ifdef KEYPAD_HISTORY_EN
    logic [15:0] r_hist;

    // shift each accepted key into the history, newest in the low nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 16'h0000;
        end else if (en && w_accept) begin
            r_hist <= {r_hist[11:0], w_code_nx};
        end
    end

    assign hexx = r_hist;
`else
    assign hexx = {12'h000, r_code};
`endif

    assign rows      = r_rows;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule

// File: tb/tb_keypad4x4_scanner.sv
// tb/tb_keypad4x4_scanner.sv - randomized and directed bench for keypad4x4_scanner against a scan-level model
`timescale 1ns/1ps
module tb_keypad4x4_scanner;

    localparam int DIV_W = 2;
    localparam int DBN   = 3;
    localparam int SCAN  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] hexx;

    logic [15:0] pressed = 16'h0000;
    int          total = 0;
    int          bad = 0;
    int          pulse_cnt = 0;
    logic        prev_valid = 1'b0;

    int          m_held;
    int          m_run_key;
    int          m_run_len;
    int          m_rel_run;
    int          m_pulses;
    logic [3:0]  m_code;
    logic [15:0] m_hist;

    keypad4x4_scanner #(.SCAN_DIV_W(DIV_W), .DEBOUNCE_SCANS(DBN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .hexx      (hexx)
    );

    always #5 clk = ~clk;

    // keypad matrix: a column reads low when a pressed key sits on a driven row
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
            end
        end
    end

    // count pulses and require each to last one cycle
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            total++;
            assert (prev_valid === 1'b0) else begin
                bad++;
                $error("FAIL pulse_width observed=%b expected=0", prev_valid);
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] kmap(input int idx);
        case (idx)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
            4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
            8: return 4'h7;  9: return 4'h8;  10: return 4'h9; 11: return 4'hC;
            12: return 4'hE; 13: return 4'h0; 14: return 4'hF; default: return 4'hD;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset_all();
        m_held = -1; m_run_key = -1; m_run_len = 0; m_rel_run = 0;
        m_code = 4'h0; m_hist = 16'h0000;
    endtask

    // one full scan of a constant key pattern, applied with the debounce rules
    task automatic model_scan(input logic [15:0] m);
        int n;
        int k;
        n = $countones(m);
        k = -1;
        for (int i = 0; i < 16; i++) if (m[i] && n == 1) k = i;
        if (m_held < 0) begin
            if (n == 1) begin
                if (k == m_run_key && m_run_len > 0) m_run_len++;
                else begin m_run_key = k; m_run_len = 1; end
                if (m_run_len == DBN) begin
                    m_held = k; m_rel_run = 0; m_run_len = 0; m_pulses++;
                    m_code = kmap(k);
                    m_hist = {m_hist[11:0], m_code};
                end
            end else begin
                m_run_len = 0;
            end
        end else begin
            if (n == 1 && k == m_held) m_rel_run = 0;
            else if (n < 2) begin
                m_rel_run++;
                if (m_rel_run == DBN) begin m_held = -1; m_run_len = 0; m_rel_run = 0; end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] exp_hexx;
        logic        exp_held;
`ifdef KEYPAD_HISTORY_EN
        exp_hexx = m_hist;
`else
        exp_hexx = {12'h000, m_code};
`endif
        exp_held = (m_held >= 0);
        check({tag, "_pulses"}, 16'(pulse_cnt), 16'(m_pulses));
        check({tag, "_held"}, {15'd0, key_held}, {15'd0, exp_held});
        check({tag, "_code"}, {12'd0, key_code}, {12'd0, m_code});
        check({tag, "_hexx"}, hexx, exp_hexx);
    endtask

    // caller is one cycle into row 0; returns one cycle into row 0 of the next scan
    task automatic do_scan(input logic [15:0] m, input string tag);
        pressed = m;
        repeat (SCAN) @(negedge clk);
        #1;
        model_scan(m);
        check_outputs(tag);
    endtask

    task automatic scans(input logic [15:0] m, input int n, input string tag);
        for (int i = 0; i < n; i++) do_scan(m, tag);
    endtask

    task automatic drop_en(input string tag);
        en = 1'b0;
        @(negedge clk);
        #1;
        m_held = -1; m_run_len = 0; m_rel_run = 0;
        check({tag, "_rows_off"}, {12'd0, rows}, 16'h000F);
        check_outputs(tag);
    endtask

    task automatic raise_en();
        en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  exp_rows;
        logic [15:0] rm;
        int          kind;
        int          a;
        int          b;
        int          len;

        model_reset_all();
        m_pulses = 0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rows", {12'd0, rows}, 16'h000F);
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        check_outputs("rst");

        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("first_rows", {12'd0, rows}, 16'h000E);

        // row strobe sequence with no key
        for (int i = 0; i < SCAN; i++) begin
            exp_rows = ~(4'b0001 << (((i + 1) / 4) % 4));
            check("row_seq", {12'd0, rows}, {12'd0, exp_rows});
            @(negedge clk);
            #1;
        end
        model_scan(16'h0000);
        check_outputs("idle");

        scans(16'h0040, 5, "hold6");
        scans(16'h0000, 3, "rel6");

        scans(16'h0040, 2, "bounce_a");
        scans(16'h0000, 1, "bounce_gap");
        scans(16'h0040, 3, "bounce_b");
        scans(16'h0000, 3, "bounce_rel");

        scans(16'h0420, 4, "ghost");
        scans(16'h0000, 1, "ghost_gap");
        scans(16'h0020, 4, "hold5");
        scans(16'h0420, 3, "hold5_add9");
        scans(16'h0000, 3, "rel5");

        for (int k = 0; k < 4; k++) begin
            scans(16'(1 << k), 3, "seq");
            scans(16'h0000, 3, "seq_rel");
        end
`ifdef KEYPAD_HISTORY_EN
        check("history_123A", hexx, 16'h123A);
`else
        check("last_A", hexx, 16'h000A);
`endif

        scans(16'h0040, 4, "en_hold6");
        drop_en("en_drop");
        raise_en();
        scans(16'h0040, 3, "en_rehold6");
        scans(16'h0000, 3, "en_rel6");

        // random key patterns held for random numbers of scans
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            if (kind == 0) rm = 16'h0000;
            else if (kind == 3) rm = 16'(1 << a) | 16'(1 << b);
            else rm = 16'(1 << a);
            len = $urandom_range(1, 5);
            scans(rm, len, "rand");
        end

        // asynchronous reset while a key is held
        scans(16'h0008, 4, "pre_rst");
        rst_n = 1'b0;
        #1;
        model_reset_all();
        check("midrst_rows", {12'd0, rows}, 16'h000F);
        check("midrst_valid", {15'd0, key_valid}, 16'd0);
        check_outputs("midrst");
        pressed = 16'h0000;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        scans(16'h8000, 3, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
